// File: rtl/writeback_stage_p.sv
// MIPS writeback stage: MEM/WB pipeline register, sub-word load extraction,
// 4-way result select, $zero write suppression and a retired-instruction counter.
module writeback_stage_p #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SUPPRESS_R0    = 1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      ValidIn,
    input  logic                      RegWriteIn,
    input  logic [1:0]                WBSel,
    input  logic [1:0]                LoadSize,
    input  logic                      LoadUnsigned,
    input  logic [REG_ADDR_WIDTH-1:0] WriteRegIn,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic [DATA_WIDTH-1:0]     DataMemory,
    input  logic [DATA_WIDTH-1:0]     LinkAddr,
    input  logic [DATA_WIDTH-1:0]     AuxData,
    output logic [DATA_WIDTH-1:0]     WriteData,
    output logic [REG_ADDR_WIDTH-1:0] WriteReg,
    output logic                      RegWrite,
    output logic                      ValidOut,
    output logic [CNT_WIDTH-1:0]      InstrRetired
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    logic                      regValid;
    logic                      regRegWrite;
    logic [1:0]                regWBSel;
    logic [1:0]                regLoadSize;
    logic                      regLoadUnsigned;
    logic [REG_ADDR_WIDTH-1:0] regWriteReg;
    logic [DATA_WIDTH-1:0]     regALUResult;
    logic [DATA_WIDTH-1:0]     regDataMemory;
    logic [DATA_WIDTH-1:0]     regLinkAddr;
    logic [DATA_WIDTH-1:0]     regAuxData;
    logic [CNT_WIDTH-1:0]      retiredCount;

    // Stage control: Reset beats Flush beats Stall. A flushed slot becomes a
    // bubble (valid and write-enable cleared); its data fields are don't-care.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            regValid        <= 1'b0;
            regRegWrite     <= 1'b0;
            regWBSel        <= '0;
            regLoadSize     <= '0;
            regLoadUnsigned <= 1'b0;
            regWriteReg     <= '0;
            regALUResult    <= '0;
            regDataMemory   <= '0;
            regLinkAddr     <= '0;
            regAuxData      <= '0;
        end else if (Flush) begin
            regValid        <= 1'b0;
            regRegWrite     <= 1'b0;
            regWBSel        <= WBSel;
            regLoadSize     <= LoadSize;
            regLoadUnsigned <= LoadUnsigned;
            regWriteReg     <= WriteRegIn;
            regALUResult    <= ALUResult;
            regDataMemory   <= DataMemory;
            regLinkAddr     <= LinkAddr;
            regAuxData      <= AuxData;
        end else if (!Stall) begin
            regValid        <= ValidIn;
            regRegWrite     <= RegWriteIn;
            regWBSel        <= WBSel;
            regLoadSize     <= LoadSize;
            regLoadUnsigned <= LoadUnsigned;
            regWriteReg     <= WriteRegIn;
            regALUResult    <= ALUResult;
            regDataMemory   <= DataMemory;
            regLinkAddr     <= LinkAddr;
            regAuxData      <= AuxData;
        end
    end

    // An instruction retires when it leaves WB, i.e. on an unstalled edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            retiredCount <= '0;
        end else if (regValid && !Stall) begin
            retiredCount <= retiredCount + 1'b1;
        end
    end

    logic [OFF_W-1:0]      regOff;
    logic [OFF_W+2:0]      byteShift;
    logic [OFF_W+2:0]      halfShift;
    logic [DATA_WIDTH-1:0] byteShifted;
    logic [DATA_WIDTH-1:0] halfShifted;
    logic [7:0]            byteVal;
    logic [15:0]           halfVal;
    logic                  byteSign;
    logic                  halfSign;
    logic [DATA_WIDTH-1:0] byteExt;
    logic [DATA_WIDTH-1:0] halfExt;
    logic [DATA_WIDTH-1:0] wordExt;
    logic [DATA_WIDTH-1:0] doubleExt;
    logic [DATA_WIDTH-1:0] loadExt;

    assign regOff      = regALUResult[OFF_W-1:0];
    assign byteShift   = {regOff, 3'b000};
    assign halfShift   = {regOff[OFF_W-1:1], 4'b0000};
    assign byteShifted = regDataMemory >> byteShift;
    assign halfShifted = regDataMemory >> halfShift;
    assign byteVal     = byteShifted[7:0];
    assign halfVal     = halfShifted[15:0];
    assign byteSign    = ~regLoadUnsigned & byteVal[7];
    assign halfSign    = ~regLoadUnsigned & halfVal[15];
    assign byteExt     = {{(DATA_WIDTH-8){byteSign}}, byteVal};
    assign halfExt     = {{(DATA_WIDTH-16){halfSign}}, halfVal};

    generate
        if (DATA_WIDTH == 64) begin : gen_w64
            // Word lane chosen by offset bit 2; the word is then extended.
            logic [DATA_WIDTH-1:0] wordShifted;
            logic [31:0]           wordVal;
            logic                  wordSign;
            assign wordShifted = regDataMemory >> {regOff[OFF_W-1], 5'b00000};
            assign wordVal     = wordShifted[31:0];
            assign wordSign    = ~regLoadUnsigned & wordVal[31];
            assign wordExt     = {{(DATA_WIDTH-32){wordSign}}, wordVal};
            assign doubleExt   = regDataMemory;
        end else begin : gen_w32
            // Word and doubleword both pass the raw memory word through.
            assign wordExt   = regDataMemory;
            assign doubleExt = regDataMemory;
        end
    endgenerate

    always_comb begin
        loadExt = doubleExt;
        case (regLoadSize)
            SIZE_WORD: loadExt = wordExt;
            SIZE_HALF: loadExt = halfExt;
            SIZE_BYTE: loadExt = byteExt;
            default:   loadExt = doubleExt;
        endcase
    end

    always_comb begin
        WriteData = regAuxData;
        case (regWBSel)
            SEL_ALU:  WriteData = regALUResult;
            SEL_MEM:  WriteData = loadExt;
            SEL_LINK: WriteData = regLinkAddr;
            default:  WriteData = regAuxData;
        endcase
    end

    logic isR0;
    assign isR0 = (SUPPRESS_R0 != 0) && (regWriteReg == '0);

    // Gated by regValid so a bubble never writes, whatever its fields hold.
    assign RegWrite     = regRegWrite & regValid & ~isR0;
    assign WriteReg     = regWriteReg;
    assign ValidOut     = regValid;
    assign InstrRetired = retiredCount;

endmodule

// File: tb/tb_writeback_stage_p.sv
// Directed bench for writeback_stage_p: reset, ALU/load/link/aux writeback,
// stall/flush behaviour and counter wrap on a 4-bit-counter instance.
module tb_writeback_stage_p;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic        ValidIn;
    logic        RegWriteIn;
    logic [1:0]  WBSel;
    logic [1:0]  LoadSize;
    logic        LoadUnsigned;
    logic [4:0]  WriteRegIn;
    logic [31:0] ALUResult;
    logic [31:0] DataMemory;
    logic [31:0] LinkAddr;
    logic [31:0] AuxData;

    logic [31:0] WriteData;
    logic [4:0]  WriteReg;
    logic        RegWrite;
    logic        ValidOut;
    logic [31:0] InstrRetired;

    logic [31:0] smallWriteData;
    logic [4:0]  smallWriteReg;
    logic        smallRegWrite;
    logic        smallValidOut;
    logic [3:0]  smallInstrRetired;

    int checks   = 0;
    int failures = 0;

    writeback_stage_p #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SUPPRESS_R0(1), .CNT_WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .ValidIn(ValidIn), .RegWriteIn(RegWriteIn), .WBSel(WBSel),
        .LoadSize(LoadSize), .LoadUnsigned(LoadUnsigned), .WriteRegIn(WriteRegIn),
        .ALUResult(ALUResult), .DataMemory(DataMemory), .LinkAddr(LinkAddr),
        .AuxData(AuxData), .WriteData(WriteData), .WriteReg(WriteReg),
        .RegWrite(RegWrite), .ValidOut(ValidOut), .InstrRetired(InstrRetired)
    );

    writeback_stage_p #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SUPPRESS_R0(1), .CNT_WIDTH(4)) dutSmall (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .ValidIn(ValidIn), .RegWriteIn(RegWriteIn), .WBSel(WBSel),
        .LoadSize(LoadSize), .LoadUnsigned(LoadUnsigned), .WriteRegIn(WriteRegIn),
        .ALUResult(ALUResult), .DataMemory(DataMemory), .LinkAddr(LinkAddr),
        .AuxData(AuxData), .WriteData(smallWriteData), .WriteReg(smallWriteReg),
        .RegWrite(smallRegWrite), .ValidOut(smallValidOut), .InstrRetired(smallInstrRetired)
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic driveSlot(input logic valid, input logic rw, input logic [1:0] sel,
                             input logic [1:0] size, input logic uns, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] mem,
                             input logic [31:0] link, input logic [31:0] aux);
        ValidIn      = valid;
        RegWriteIn   = rw;
        WBSel        = sel;
        LoadSize     = size;
        LoadUnsigned = uns;
        WriteRegIn   = rd;
        ALUResult    = alu;
        DataMemory   = mem;
        LinkAddr     = link;
        AuxData      = aux;
    endtask

    task automatic driveIdle();
        driveSlot(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // Load vectors with DataMemory = 0x80FF_7F80: {size, unsigned, ALUResult, expected}
    logic [1:0]  ldSize [9] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11};
    logic        ldUns  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ldAlu  [9] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h2, 32'h3, 32'h2, 32'h1, 32'h0};
    logic [31:0] ldExp  [9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                                32'hFFFF_80FF, 32'h0000_80FF, 32'hFFFF_80FF,
                                32'h0000_00FF, 32'h80FF_7F80, 32'h80FF_7F80};

    initial begin
        Reset = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        driveIdle();
        step();
        step();
        Reset = 1'b0;
        step();
        checkVal("rst_wdata", WriteData, 32'h0);
        checkVal("rst_regwrite", RegWrite, 1'b0);
        checkVal("rst_valid", ValidOut, 1'b0);
        checkVal("rst_retired", InstrRetired, 32'd0);

        driveSlot(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd8, 32'h0000_1234, 32'h0, 32'h0, 32'h0);
        step();
        checkVal("alu_wdata", WriteData, 32'h0000_1234);
        checkVal("alu_wreg", WriteReg, 5'd8);
        checkVal("alu_regwrite", RegWrite, 1'b1);
        checkVal("alu_valid", ValidOut, 1'b1);
        checkVal("alu_retired_before", InstrRetired, 32'd0);

        for (int i = 0; i < 9; i++) begin
            driveSlot(1'b1, 1'b1, 2'b01, ldSize[i], ldUns[i], 5'd9, ldAlu[i], 32'h80FF_7F80, 32'h0, 32'h0);
            step();
            checkVal($sformatf("load%0d_wdata", i), WriteData, ldExp[i]);
            checkVal($sformatf("load%0d_retired", i), InstrRetired, 32'(i + 1));
        end

        driveSlot(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 5'd31, 32'h0, 32'h0, 32'h0040_0008, 32'h0);
        step();
        checkVal("link_wdata", WriteData, 32'h0040_0008);
        checkVal("link_wreg", WriteReg, 5'd31);
        checkVal("link_regwrite", RegWrite, 1'b1);
        checkVal("link_retired", InstrRetired, 32'd10);

        driveSlot(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
        step();
        checkVal("aux_wdata", WriteData, 32'hDEAD_BEEF);
        checkVal("aux_r0_regwrite", RegWrite, 1'b0);
        checkVal("aux_valid", ValidOut, 1'b1);
        checkVal("aux_retired", InstrRetired, 32'd11);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            driveSlot(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'(3 + i), 32'(32'h5555 + i), 32'h0, 32'h0, 32'h0);
            step();
            checkVal($sformatf("stall%0d_wdata", i), WriteData, 32'hDEAD_BEEF);
            checkVal($sformatf("stall%0d_wreg", i), WriteReg, 5'd0);
            checkVal($sformatf("stall%0d_valid", i), ValidOut, 1'b1);
            checkVal($sformatf("stall%0d_retired", i), InstrRetired, 32'd11);
        end

        Flush = 1'b1;
        step();
        checkVal("stallflush_valid", ValidOut, 1'b0);
        checkVal("stallflush_regwrite", RegWrite, 1'b0);
        checkVal("stallflush_retired", InstrRetired, 32'd11);

        Stall = 1'b0;
        Flush = 1'b0;
        driveSlot(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd3, 32'h0000_5555, 32'h0, 32'h0, 32'h0);
        step();
        checkVal("resume_wdata", WriteData, 32'h0000_5555);
        checkVal("resume_regwrite", RegWrite, 1'b1);
        checkVal("resume_retired", InstrRetired, 32'd11);
        driveIdle();
        step();
        checkVal("idle_valid", ValidOut, 1'b0);
        checkVal("idle_retired", InstrRetired, 32'd12);

        Flush = 1'b1;
        driveSlot(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd4, 32'h0000_0777, 32'h0, 32'h0, 32'h0);
        step();
        checkVal("flush_valid", ValidOut, 1'b0);
        checkVal("flush_regwrite", RegWrite, 1'b0);
        checkVal("flush_retired", InstrRetired, 32'd12);
        Flush = 1'b0;

        // Counter wrap on the 4-bit instance.
        Reset = 1'b1;
        driveIdle();
        step();
        Reset = 1'b0;
        checkVal("wrap_start", smallInstrRetired, 4'd0);
        driveSlot(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd5, 32'h0000_0042, 32'h0, 32'h0, 32'h0);
        step();
        checkVal("wrap_first_slot", smallInstrRetired, 4'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) checkVal("wrap_at_15", smallInstrRetired, 4'd15);
        end
        checkVal("wrap_to_zero", smallInstrRetired, 4'd0);
        checkVal("wide_at_16", InstrRetired, 32'd16);

        // Mid-stream reset, even with Stall asserted.
        Reset = 1'b1;
        Stall = 1'b1;
        step();
        checkVal("midrst_retired", InstrRetired, 32'd0);
        checkVal("midrst_small_retired", smallInstrRetired, 4'd0);
        checkVal("midrst_valid", ValidOut, 1'b0);
        checkVal("midrst_wdata", WriteData, 32'h0);
        checkVal("midrst_regwrite", RegWrite, 1'b0);
        Reset = 1'b0;
        Stall = 1'b0;
        driveIdle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
